// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned A-B with registered borrow and valid/ready input
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH:0]   Output
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_sr_q, a_sr_d;
    logic [WIDTH-1:0]  b_sr_q, b_sr_d;
    logic [WIDTH-1:0]  diff_sr_q, diff_sr_d;
    logic              bor_q, bor_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH:0]    result_q, result_d;

    logic              bit_a, bit_b, bit_d, bor_next;

    // Single full-subtractor cell working on the LSBs of the operand shift registers
    always_comb begin
        bit_a    = a_sr_q[0];
        bit_b    = b_sr_q[0];
        bit_d    = bit_a ^ bit_b ^ bor_q;
        bor_next = (~bit_a & bit_b) | (~bit_a & bor_q) | (bit_b & bor_q);
    end

    always_comb begin
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        diff_sr_d = diff_sr_q;
        bor_d     = bor_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sr_d    = A;
                    b_sr_d    = B;
                    diff_sr_d = '0;
                    bor_d     = 1'b0;
                    cnt_d     = '0;
                    state_d   = CALC;
                end
            end
            CALC: begin
                a_sr_d    = a_sr_q >> 1;
                b_sr_d    = b_sr_q >> 1;
                diff_sr_d = {bit_d, diff_sr_q[WIDTH-1:1]};
                bor_d     = bor_next;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // diff_sr_d already holds the complete difference, LSB at bit 0
                    result_d = {bor_next, diff_sr_d};
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            diff_sr_q <= '0;
            bor_q     <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            a_sr_q    <= a_sr_d;
            b_sr_q    <= b_sr_d;
            diff_sr_q <= diff_sr_d;
            bor_q     <= bor_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Output    = result_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] A = '0;
    logic [3:0] B = '0;
    logic       in_ready;
    logic       out_valid;
    logic [4:0] Output;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    serial_subtractor #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .Output    (Output)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: edge index, accept edge, result timing from latency rules
    int         e = 0;
    bit         m_busy = 0;
    int         m_acc_e = 0;
    logic [4:0] m_out = '0;
    logic [4:0] m_pend = '0;
    int         acc_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0;
            m_out  = '0;
        end else begin
            e++;
            if (m_busy) begin
                if (e == m_acc_e + 4) m_out = m_pend;
                if (e == m_acc_e + 5) m_busy = 0;
            end else if (in_valid) begin
                m_busy  = 1;
                m_acc_e = e;
                m_pend  = {1'b0, A} - {1'b0, B};
                acc_q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, !m_busy);
        chk("out_valid", out_valid, (rst_n && m_busy && e == m_acc_e + 4));
        chk("Output", Output, m_out);
        if (out_valid) pulses++;
    end

    task automatic wait_ready();
        int k;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (k == 20) chk("ready_timeout", 0, 1);
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [4:0] exp, input string name);
        int k;
        wait_ready();
        in_valid = 1'b1;
        A = a;
        B = b;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) break;
        end
        chk({name, "_latency"}, k, 4);
        chk({name, "_result"}, Output, exp);
        chk({name, "_borrow"}, Output[4], (a < b));
    endtask

    initial begin
        int p0;
        int n0;
        logic [3:0] pa [4];
        logic [3:0] pb [4];
        pa = '{4'd9, 4'd3, 4'd14, 4'd0};
        pb = '{4'd3, 4'd9, 4'd1, 4'd15};

        #12;
        chk("reset_ready", in_ready, 1);
        chk("reset_valid", out_valid, 0);
        chk("reset_output", Output, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'd9, 4'd3, 5'b0_0110, "basic");
        run_op(4'd3, 4'd9, 5'b1_1010, "borrow");
        run_op(4'd0, 4'd1, 5'b1_1111, "zero_minus_one");
        run_op(4'd15, 4'd15, 5'b0_0000, "equal");

        // in_valid held high through CALC and the DONE edge with other operands
        wait_ready();
        p0 = pulses;
        @(posedge clk);
        #1 in_valid = 1'b1; A = 4'd12; B = 4'd5;
        @(posedge clk);
        #1 A = 4'd1; B = 4'd2;
        repeat (5) @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_result", Output, 5'b0_0111);
        chk("busy_pulses", pulses - p0, 1);

        // Abort in the middle of the computation
        wait_ready();
        p0 = pulses;
        in_valid = 1'b1; A = 4'd10; B = 4'd4;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("abort_output", Output, 0);
        chk("abort_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_pulses", pulses - p0, 0);
        chk("abort_output_after", Output, 0);
        run_op(4'd7, 4'd2, 5'b0_0101, "after_abort");

        // Back-to-back with in_valid held high
        wait_ready();
        n0 = acc_q.size();
        p0 = pulses;
        in_valid = 1'b1; A = pa[0]; B = pb[0];
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            if (i < 3) begin
                #1 A = pa[i+1]; B = pb[i+1];
                repeat (5) @(posedge clk);
            end else begin
                #1 in_valid = 1'b0;
            end
        end
        repeat (7) @(negedge clk);
        chk("b2b_accepts", acc_q.size() - n0, 4);
        chk("b2b_pulses", pulses - p0, 4);
        for (int i = n0 + 1; i < acc_q.size(); i++)
            chk("b2b_spacing", acc_q[i] - acc_q[i-1], 6);
        chk("b2b_last", Output, 5'b1_0001);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                run_op(4'(a), 4'(b), 5'((a - b) & 31), "exhaustive");

        repeat (8) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
